// File: rtl/axi_ic_pkg.sv
// Shared encodings for the AXI interconnect write path: grant codes, owner and FSM state types.
package axi_ic_pkg;

    localparam logic [1:0] MSEL_NONE = 2'b00;
    localparam logic [1:0] MSEL_M1   = 2'b01;
    localparam logic [1:0] MSEL_M2   = 2'b10;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M1   = 2'd1,
        OWN_M2   = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_state_e;

endpackage

// File: rtl/axi_burst_cnt.sv
// Write-burst beat counter: latches AWLEN, counts W beats, flags the last beat and WLAST mismatches.
module axi_burst_cnt #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    input  logic             beat,
    input  logic             wlast,
    output logic             last_c,
    output logic             mismatch_c
);

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;

    // Counter holds on the final beat so a max-length burst never wraps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q    <= '0;
            beat_cnt <= '0;
        end else if (load) begin
            len_q    <= len;
            beat_cnt <= '0;
        end else if (beat && !last_c) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
        end
    end

    assign last_c     = (beat_cnt == len_q);
    assign mismatch_c = beat && (wlast != last_c);

endmodule

// File: rtl/axi_wr_path_mux.sv
// Routes the granted master's AXI write channels to the slave and tracks one burst to its B handshake.
module axi_wr_path_mux
    import axi_ic_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          mas_sel,

    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [LEN_W-1:0]    m1_awlen,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [ID_W-1:0]     m1_bid,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,

    input  logic [ADDR_W-1:0]   m2_awaddr,
    input  logic [ID_W-1:0]     m2_awid,
    input  logic [LEN_W-1:0]    m2_awlen,
    input  logic                m2_awvalid,
    output logic                m2_awready,
    input  logic [DATA_W-1:0]   m2_wdata,
    input  logic [DATA_W/8-1:0] m2_wstrb,
    input  logic                m2_wlast,
    input  logic                m2_wvalid,
    output logic                m2_wready,
    output logic [ID_W-1:0]     m2_bid,
    output logic [1:0]          m2_bresp,
    output logic                m2_bvalid,
    input  logic                m2_bready,

    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [ID_W-1:0]     s_awid,
    output logic [LEN_W-1:0]    s_awlen,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [ID_W-1:0]     s_bid,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready,

    output logic                endtrans,
    output logic                busy,
    output logic                protocol_err
);

    wr_state_e state, state_nxt;
    owner_e    owner, owner_nxt;

    logic own1, own2;
    logic in_addr, in_data, in_resp;
    logic aw_hs, w_hs, b_hs;
    logic last_c, mismatch_c;

    assign own1    = (owner == OWN_M1);
    assign own2    = (owner == OWN_M2);
    assign in_addr = (state == ADDR);
    assign in_data = (state == DATA);
    assign in_resp = (state == RESP);

    // AW channel: payload follows the owner, handshake signals gated by phase.
    assign s_awaddr   = own2 ? m2_awaddr : m1_awaddr;
    assign s_awid     = own2 ? m2_awid   : m1_awid;
    assign s_awlen    = own2 ? m2_awlen  : m1_awlen;
    assign s_awvalid  = in_addr && ((own1 && m1_awvalid) || (own2 && m2_awvalid));
    assign m1_awready = in_addr && own1 && s_awready;
    assign m2_awready = in_addr && own2 && s_awready;

    assign s_wdata    = own2 ? m2_wdata : m1_wdata;
    assign s_wstrb    = own2 ? m2_wstrb : m1_wstrb;
    assign s_wlast    = own2 ? m2_wlast : m1_wlast;
    assign s_wvalid   = in_data && ((own1 && m1_wvalid) || (own2 && m2_wvalid));
    assign m1_wready  = in_data && own1 && s_wready;
    assign m2_wready  = in_data && own2 && s_wready;

    assign m1_bid     = own1 ? s_bid   : '0;
    assign m1_bresp   = own1 ? s_bresp : 2'b00;
    assign m2_bid     = own2 ? s_bid   : '0;
    assign m2_bresp   = own2 ? s_bresp : 2'b00;
    assign m1_bvalid  = in_resp && own1 && s_bvalid;
    assign m2_bvalid  = in_resp && own2 && s_bvalid;
    assign s_bready   = in_resp && ((own1 && m1_bready) || (own2 && m2_bready));

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign b_hs  = s_bvalid && s_bready;
    assign busy  = (state != IDLE);

    axi_burst_cnt #(
        .LEN_W (LEN_W)
    ) u_burst_cnt (
        .clk        (clk),
        .rstn       (rstn),
        .load       (aw_hs),
        .len        (s_awlen),
        .beat       (w_hs),
        .wlast      (s_wlast),
        .last_c     (last_c),
        .mismatch_c (mismatch_c)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            owner        <= OWN_NONE;
            endtrans     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            owner        <= owner_nxt;
            endtrans     <= in_resp && b_hs;
            protocol_err <= protocol_err || mismatch_c;
        end
    end

    // Owner is captured on grant and held until the burst's B handshake.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            IDLE: begin
                if (mas_sel == MSEL_M1) begin
                    owner_nxt = OWN_M1;
                    state_nxt = ADDR;
                end else if (mas_sel == MSEL_M2) begin
                    owner_nxt = OWN_M2;
                    state_nxt = ADDR;
                end
            end
            ADDR: if (aw_hs) state_nxt = DATA;
            DATA: if (w_hs && last_c) state_nxt = RESP;
            RESP: begin
                if (b_hs) begin
                    state_nxt = IDLE;
                    owner_nxt = OWN_NONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
            end
        endcase
    end

endmodule
